rc4_keystream_core: RTL and testbench

Parametrised RC4 cipher core for the encrypted-microprocessor datapath, generalising the fixed 4-bit RC4 datapath to a configurable word width and key length. It runs S-box initialisation, the key-scheduling algorithm (KSA) and the pseudo-random generation algorithm (PRGA) under one FSM. It delivers keystream words over a valid/ready handshake to the encrypt/decrypt stage feeding the processor's instruction/data path.

---
 rtl/rc4_keystream_core_if.sv | 21 ++
 rtl/rc4_keystream_core.sv | 190 +++++++++++++++++++
 tb/tb_rc4_keystream_core.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_keystream_core_if.sv
// Handshake bundle for rc4_keystream_core: key loading, run control, status and keystream output.
interface rc4_keystream_core_if #(
    parameter int WIDTH = 4,
    parameter int KAW   = 4
);
    logic             key_wr;
    logic [KAW-1:0]   key_addr;
    logic [WIDTH-1:0] key_data;
    logic             start;
    logic             stop;
    logic             busy;
    logic             ksa_done;
    logic             ks_valid;
    logic             ks_ready;
    logic [WIDTH-1:0] ks_data;

    modport master (output key_wr, key_addr, key_data, start, stop, ks_ready,
                    input  busy, ksa_done, ks_valid, ks_data);
    modport slave  (input  key_wr, key_addr, key_data, start, stop, ks_ready,
                    output busy, ksa_done, ks_valid, ks_data);
endinterface

// File: rtl/rc4_keystream_core.sv
// Parametrised RC4 core: S-box init, KSA and PRGA under one FSM, keystream out over valid/ready.
// Optional RC4-dropN hardening is compiled in with the macro RC4_DROP_EN.
module rc4_keystream_core #(
    parameter int  WIDTH   = 4,
    parameter int  KEY_LEN = 16,
    parameter int  DROP_N  = 0,
    localparam int KAW     = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
    input logic                 clk,
    input logic                 reset,
    rc4_keystream_core_if.slave bus
);
    localparam int               N         = 1 << WIDTH;
    localparam logic [WIDTH-1:0] LAST      = '1;
    localparam logic [KAW-1:0]   K_LAST    = KAW'(KEY_LEN - 1);
    localparam bit               PARAMS_OK = (WIDTH >= 4) && (WIDTH <= 8) && (KEY_LEN >= 1) &&
                                             (KEY_LEN <= N) && (DROP_N >= 0);

    if (!PARAMS_OK) begin : g_bad_params
        $error("rc4_keystream_core: WIDTH, KEY_LEN or DROP_N out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
`ifdef RC4_DROP_EN
        ST_DROP,
`endif
        ST_GEN,
        ST_OUT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] i_q, i_d, j_q, j_d, t_q, t_d;
    logic [KAW-1:0]   k_q, k_d;
    logic [WIDTH-1:0] s_q   [N];
    logic [WIDTH-1:0] s_d   [N];
    logic [WIDTH-1:0] key_q [KEY_LEN];
    logic [WIDTH-1:0] key_d [KEY_LEN];

`ifdef RC4_DROP_EN
    localparam int             DCW       = (DROP_N > 1) ? $clog2(DROP_N) : 1;
    localparam logic [DCW-1:0] DROP_LAST = DCW'(DROP_N - 1);
    logic [DCW-1:0] drop_cnt_q, drop_cnt_d;
    logic           drop_ph_q, drop_ph_d;
`endif

    // Shared swap datapath: KSA swaps S[i] with key mixing, PRGA swaps S[i+1] without.
    logic [WIDTH-1:0] a_idx, key_w, s_a, j_new, s_b;

    always_comb begin
        a_idx = (state_q == ST_KSA) ? i_q : i_q + WIDTH'(1);
        key_w = (state_q == ST_KSA) ? key_q[k_q] : '0;
        s_a   = s_q[a_idx];
        j_new = j_q + s_a + key_w;
        s_b   = s_q[j_new];
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        t_d     = t_q;
        s_d     = s_q;
        key_d   = key_q;
`ifdef RC4_DROP_EN
        drop_cnt_d = drop_cnt_q;
        drop_ph_d  = drop_ph_q;
`endif
        case (state_q)
            ST_IDLE: begin
                i_d = '0;
                j_d = '0;
                k_d = '0;
                if (bus.key_wr && (int'(bus.key_addr) < KEY_LEN)) key_d[bus.key_addr] = bus.key_data;
                if (bus.start) state_d = ST_INIT;
            end
            ST_INIT: begin
                s_d[i_q] = i_q;
                i_d      = i_q + WIDTH'(1);
                if (i_q == LAST) state_d = ST_KSA;
            end
            ST_KSA: begin
                s_d[a_idx] = s_b;
                s_d[j_new] = s_a;
                j_d        = j_new;
                i_d        = i_q + WIDTH'(1);
                k_d        = (k_q == K_LAST) ? '0 : k_q + KAW'(1);
                if (i_q == LAST) begin
                    j_d = '0;
`ifdef RC4_DROP_EN
                    state_d = (DROP_N > 0) ? ST_DROP : ST_GEN;
`else
                    state_d = ST_GEN;
`endif
                end
            end
`ifdef RC4_DROP_EN
            // Phase 0 mirrors GEN, phase 1 mirrors an OUT that is accepted at once.
            ST_DROP: begin
                if (!drop_ph_q) begin
                    s_d[a_idx] = s_b;
                    s_d[j_new] = s_a;
                    i_d        = a_idx;
                    j_d        = j_new;
                    drop_ph_d  = 1'b1;
                end else begin
                    drop_ph_d = 1'b0;
                    if (drop_cnt_q == DROP_LAST) begin
                        drop_cnt_d = '0;
                        state_d    = ST_GEN;
                    end else begin
                        drop_cnt_d = drop_cnt_q + DCW'(1);
                    end
                end
            end
`endif
            ST_GEN: begin
                s_d[a_idx] = s_b;
                s_d[j_new] = s_a;
                i_d        = a_idx;
                j_d        = j_new;
                t_d        = s_a + s_b;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (bus.ks_ready) state_d = ST_GEN;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any update in flight, including a same-cycle key write.
        if (bus.stop) begin
            state_d = ST_IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            s_d     = s_q;
            key_d   = key_q;
`ifdef RC4_DROP_EN
            drop_cnt_d = '0;
            drop_ph_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            t_q     <= '0;
            // NOTE: S and key must read as zero after reset, so these arrays sit in the async-reset branch.
            for (int e = 0; e < N; e++) s_q[e] <= '0;
            for (int e = 0; e < KEY_LEN; e++) key_q[e] <= '0;
`ifdef RC4_DROP_EN
            drop_cnt_q <= '0;
            drop_ph_q  <= 1'b0;
`endif
        end else begin
            // NOTE: state registers take non-blocking assignments; only the comb blocks use blocking.
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            t_q     <= t_d;
            s_q     <= s_d;
            key_q   <= key_d;
`ifdef RC4_DROP_EN
            drop_cnt_q <= drop_cnt_d;
            drop_ph_q  <= drop_ph_d;
`endif
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
`ifdef RC4_DROP_EN
    assign bus.ksa_done = state_q inside {ST_DROP, ST_GEN, ST_OUT};
`else
    assign bus.ksa_done = state_q inside {ST_GEN, ST_OUT};
`endif
    assign bus.ks_valid = (state_q == ST_OUT);
    // S is frozen while in OUT, so S[t] is stable for as long as the word is presented.
    assign bus.ks_data  = (state_q == ST_OUT) ? s_q[t_q] : '0;

endmodule

// File: tb/tb_rc4_keystream_core.sv
// Self-checking bench for rc4_keystream_core: an 8-bit/"Key" instance and a 4-bit/16-word-key instance
// compared against a textbook RC4 model.
module tb_rc4_keystream_core;
    localparam int DN_A = 4;
`ifdef RC4_DROP_EN
    localparam int DROP_A = DN_A;
`else
    localparam int DROP_A = 0;
`endif
    localparam int N0 = 9 - DROP_A;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    rc4_keystream_core_if #(.WIDTH(8), .KAW(2)) bus_a ();
    rc4_keystream_core_if #(.WIDTH(4), .KAW(4)) bus_b ();

    rc4_keystream_core #(.WIDTH(8), .KEY_LEN(3), .DROP_N(DN_A)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    rc4_keystream_core #(.WIDTH(4), .KEY_LEN(16), .DROP_N(0)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    logic [31:0] got_q [$];
    int          ref_q [$];
    int          key_vec [$];
    int          known [9] = '{'hEB, 'h9F, 'h77, 'h81, 'hB7, 'h34, 'hCA, 'h72, 'hA7};
    int          lat;
    int          cyc_used;
    logic        busy1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_data(input bit b);
        return b ? 32'(bus_b.ks_data) : 32'(bus_a.ks_data);
    endfunction
    function automatic logic rd_valid(input bit b);
        return b ? bus_b.ks_valid : bus_a.ks_valid;
    endfunction
    function automatic logic rd_busy(input bit b);
        return b ? bus_b.busy : bus_a.busy;
    endfunction
    function automatic logic rd_done(input bit b);
        return b ? bus_b.ksa_done : bus_a.ksa_done;
    endfunction

    task automatic drive(input bit b, input logic wr, input int addr, input int data,
                         input logic st, input logic sp);
        if (b) begin
            bus_b.key_wr = wr; bus_b.key_addr = 4'(addr); bus_b.key_data = 4'(data);
            bus_b.start = st; bus_b.stop = sp;
        end else begin
            bus_a.key_wr = wr; bus_a.key_addr = 2'(addr); bus_a.key_data = 8'(data);
            bus_a.start = st; bus_a.stop = sp;
        end
    endtask

    task automatic set_ready(input bit b, input logic v);
        if (b) bus_b.ks_ready = v;
        else   bus_a.ks_ready = v;
    endtask

    // Hold the controls for exactly one rising edge.
    task automatic pulse(input bit b, input logic wr, input int addr, input int data,
                         input logic st, input logic sp);
        @(negedge clk);
        drive(b, wr, addr, data, st, sp);
        @(posedge clk);
        #1 drive(b, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Called right after a start pulse; c counts cycles after the sampling edge.
    task automatic wait_valid(input bit b, output int l, output logic bz);
        l  = 0;
        bz = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (c == 1) bz = rd_busy(b);
            if (rd_valid(b) === 1'b1) begin
                l = c;
                break;
            end
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low 5 cycles, then high.
    task automatic collect(input bit b, input int n, input int mode);
        logic [31:0] held;
        bit          hold;
        logic        rdy;
        got_q    = {};
        hold     = 1'b0;
        held     = '0;
        cyc_used = 0;
        for (int c = 0; c < 4000 && got_q.size() < n; c++) begin
            @(negedge clk);
            cyc_used++;
            if (hold) begin
                check("hold data", rd_data(b), held);
                check("hold valid", 32'(rd_valid(b)), 32'd1);
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 2) rdy = (c >= 5);
            else                rdy = ($urandom_range(0, 3) != 0);
            set_ready(b, rdy);
            hold = (rd_valid(b) === 1'b1) && !rdy;
            held = rd_data(b);
            if ((rd_valid(b) === 1'b1) && rdy) got_q.push_back(rd_data(b));
        end
        @(posedge clk);
        #1 set_ready(b, 1'b0);
        check("word count", got_q.size(), n);
    endtask

    task automatic compare(input string tag, input int offset, input int n);
        logic [31:0] obs;
        for (int w = 0; w < n; w++) begin
            obs = (w < got_q.size()) ? got_q[w] : 'x;
            check($sformatf("%s w%0d", tag, w), obs, ref_q[offset + w]);
        end
    endtask

    // Textbook RC4 over 2^width entries: KSA, then PRGA with the first 'drop' words discarded.
    function automatic void rc4_ref(input int width, input int key[$], input int drop, input int nwords);
        int n;
        int s [256];
        int i;
        int j;
        int tmp;
        n = 1 << width;
        for (int x = 0; x < n; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < n; x++) begin
            j    = (j + s[x] + key[x % key.size()]) % n;
            tmp  = s[x]; s[x] = s[j]; s[j] = tmp;
        end
        i = 0;
        j = 0;
        ref_q = {};
        for (int w = 0; w < drop + nwords; w++) begin
            i   = (i + 1) % n;
            j   = (j + s[i]) % n;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            if (w >= drop) ref_q.push_back(s[(s[i] + s[j]) % n]);
        end
    endfunction

    initial begin
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        set_ready(1'b0, 1'b0);
        set_ready(1'b1, 1'b0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst busy", 32'(bus_a.busy), 0);
        check("rst ksa_done", 32'(bus_a.ksa_done), 0);
        check("rst ks_valid", 32'(bus_a.ks_valid), 0);
        check("rst ks_data", 32'(bus_a.ks_data), 0);
        check("rst b ks_valid", 32'(bus_b.ks_valid), 0);
        check("rst b ks_data", 32'(bus_b.ks_data), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // start together with stop in IDLE stays IDLE
        pulse(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        @(negedge clk);
        check("start+stop busy", 32'(bus_a.busy), 0);

        // "Key" vector; address 3 is beyond KEY_LEN and must be ignored
        key_vec = '{'h4B, 'h65, 'h79};
        foreach (key_vec[x]) pulse(1'b0, 1'b1, x, key_vec[x], 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 3, 'hFF, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        wait_valid(1'b0, lat, busy1);
        check("key latency", lat, 514 + 2 * DROP_A);
        check("busy after start", 32'(busy1), 1);
        check("ksa_done at valid", 32'(rd_done(1'b0)), 1);
        collect(1'b0, N0, 0);
        check("throughput cycles", cyc_used, 2 * N0 - 1);
        for (int w = 0; w < N0; w++)
            check($sformatf("key vector w%0d", w), (w < got_q.size()) ? got_q[w] : 'x, known[w + DROP_A]);
        rc4_ref(8, key_vec, DROP_A, N0 + 30);
        collect(1'b0, 20, 2);
        compare("backpressure", N0, 20);
        collect(1'b0, 10, 1);
        compare("random ready", N0 + 20, 10);

        // stop from OUT, then stop mid-KSA with a key write attempted while busy
        pulse(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        check("stop busy", 32'(bus_a.busy), 0);
        check("stop ks_valid", 32'(bus_a.ks_valid), 0);
        check("stop ksa_done", 32'(bus_a.ksa_done), 0);
        pulse(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        repeat (296) @(posedge clk);
        pulse(1'b0, 1'b1, 0, 'h00, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        check("mid-KSA stop busy", 32'(bus_a.busy), 0);
        pulse(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        wait_valid(1'b0, lat, busy1);
        check("restart latency", lat, 514 + 2 * DROP_A);
        rc4_ref(8, key_vec, DROP_A, 12);
        collect(1'b0, 12, 1);
        compare("restart", 0, 12);

        // random keys with random backpressure
        for (int r = 0; r < 3; r++) begin
            pulse(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
            key_vec = '{$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
            foreach (key_vec[x]) pulse(1'b0, 1'b1, x, key_vec[x], 1'b0, 1'b0);
            pulse(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
            wait_valid(1'b0, lat, busy1);
            check($sformatf("rand%0d latency", r), lat, 514 + 2 * DROP_A);
            rc4_ref(8, key_vec, DROP_A, 16);
            collect(1'b0, 16, 1);
            compare($sformatf("rand%0d", r), 0, 16);
        end

        // 4-bit instance, key words 0..15
        key_vec = {};
        for (int x = 0; x < 16; x++) begin
            key_vec.push_back(x);
            pulse(1'b1, 1'b1, x, x, 1'b0, 1'b0);
        end
        pulse(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        wait_valid(1'b1, lat, busy1);
        check("w4 latency", lat, 34);
        check("w4 busy after start", 32'(busy1), 1);
        rc4_ref(4, key_vec, 0, 64);
        collect(1'b1, 64, 0);
        check("w4 throughput cycles", cyc_used, 127);
        compare("w4", 0, 64);

        // async reset while instance A presents a word
        @(negedge clk);
        check("pre-reset ks_valid", 32'(bus_a.ks_valid), 1);
        #2 reset = 1'b0;
        #1;
        check("async rst ks_valid", 32'(bus_a.ks_valid), 0);
        check("async rst busy", 32'(bus_a.busy), 0);
        check("async rst ks_data", 32'(bus_a.ks_data), 0);
        @(negedge clk);
        reset = 1'b1;
        pulse(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        wait_valid(1'b0, lat, busy1);
        check("post-reset latency", lat, 514 + 2 * DROP_A);
        key_vec = '{0, 0, 0};
        rc4_ref(8, key_vec, DROP_A, 8);
        collect(1'b0, 8, 1);
        compare("zero key", 0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
